// File: rtl/cpu_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_multicycle_ctrl
//   Multi-cycle main control FSM for an RV32I core. Sequences a single shared
//   memory port, the ALU, the register file and the PC through
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB]. Control strobes are decoded from
//   the state register and the latched opcode. Only ir_write, pc_write and
//   pc_src also depend on inputs (mem_ready, zero).
//
// Optional feature (compile-time macro):
//   CTRL_ILLEGAL_TRAP_EN  - illegal opcode in DECODE enters TRAP, holds trap=1
//                           until reset. When undefined, an illegal opcode is
//                           a NOP (DECODE -> FETCH) and trap is tied low.
//
// Parameters:
//   MEM_WAIT_MAX  - cycles a request may wait for mem_ready before mem_err sets
//
// Ports:
//   clk          in   1  clock, all logic on posedge
//   rst          in   1  synchronous active-high reset; forces outputs to 0
//   instruction  in   7  opcode field of memory read data (sampled on fetch)
//   zero         in   1  ALU zero flag (branch decision in EXEC)
//   mem_ready    in   1  memory completes the current request this cycle
//   mem_req      out  1  memory request, held until mem_ready
//   mem_we       out  1  request is a write
//   ir_write     out  1  load instruction register
//   pc_write     out  1  update PC
//   pc_src       out  1  0: PC+4, 1: branch/jump target
//   alu_src      out  1  0: rs2, 1: immediate
//   alu_op       out  2  00 add, 01 sub/compare, 10 funct-decoded
//   mem_to_reg   out  1  writeback selects memory data
//   reg_write    out  1  register file write enable
//   mem_err      out  1  sticky: a request waited MEM_WAIT_MAX cycles
//   trap         out  1  illegal-opcode halt indicator
//   state        out  3  FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
// -----------------------------------------------------------------------------
module cpu_multicycle_ctrl #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] instruction,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       alu_src,
   output logic [1:0] alu_op,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       mem_err,
   output logic       trap,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam int WW = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_WAIT_MAX);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);

   state_t        state_q;
   logic [6:0]    op_q;
   logic [WW-1:0] wait_cnt;
   logic          mem_err_q;

   logic is_r, is_i, is_load, is_store, is_branch, is_jal, legal;
   logic req_active;

   assign is_r      = (op_q == OP_R);
   assign is_i      = (op_q == OP_I);
   assign is_load   = (op_q == OP_LOAD);
   assign is_store  = (op_q == OP_STORE);
   assign is_branch = (op_q == OP_BRANCH);
   assign is_jal    = (op_q == OP_JAL);
   assign legal     = is_r | is_i | is_load | is_store | is_branch | is_jal;

   // Raw request, independent of rst; the port version is masked below.
   assign req_active = (state_q == S_FETCH) || (state_q == S_MEM);

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every branch below sees the pre-edge values of state_q/op_q/wait_cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         wait_cnt  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         // Wait counter: zero outside a request and on completion, so it is
         // already clear on entry to FETCH/MEM. Completion beats the timeout.
         if (!req_active || mem_ready) begin
            wait_cnt <= '0;
         end else begin
            if (wait_cnt != WAIT_MAX)
               wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_LAST)
               mem_err_q <= 1'b1;
         end

         case (state_q)
            S_FETCH: begin
               if (mem_ready) begin
                  op_q    <= instruction;
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (legal)
                  state_q <= S_EXEC;
               else
`ifdef CTRL_ILLEGAL_TRAP_EN
                  state_q <= S_TRAP;
`else
                  state_q <= S_FETCH;  // PC already advanced: acts as a NOP
`endif
            end
            S_EXEC: begin
               if (is_load || is_store)
                  state_q <= S_MEM;
               else if (is_r || is_i || is_jal)
                  state_q <= S_WB;
               else
                  state_q <= S_FETCH;
            end
            S_MEM: begin
               if (mem_ready)
                  state_q <= is_load ? S_WB : S_FETCH;
            end
            S_WB: state_q <= S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: state_q <= S_TRAP;  // only rst leaves TRAP
`endif
            default: state_q <= S_FETCH;
         endcase
      end
   end

   // NOTE: every output gets a default before the case, so no latch can be
   // inferred for a state/opcode combination that assigns nothing.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      // Reset is synchronous, so the state register may still hold an old
      // state during the rst cycle; mask the strobes to drop any request.
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req  = 1'b1;
               ir_write = mem_ready;
               pc_write = mem_ready;  // pc_src stays 0: PC+4
            end
            S_EXEC: begin
               if (is_r) begin
                  alu_op = 2'b10;
               end else if (is_i) begin
                  alu_src = 1'b1;
                  alu_op  = 2'b10;
               end else if (is_load || is_store) begin
                  alu_src = 1'b1;
               end else if (is_branch) begin
                  alu_op   = 2'b01;
                  pc_write = zero;
                  pc_src   = zero;
               end else if (is_jal) begin
                  pc_write = 1'b1;
                  pc_src   = 1'b1;
               end
            end
            S_MEM: begin
               mem_req = 1'b1;
               mem_we  = is_store;
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = is_load;
            end
            default: ;
         endcase
      end
   end

   assign mem_err = !rst && mem_err_q;
   assign state   = rst ? 3'd0 : state_q;

`ifdef CTRL_ILLEGAL_TRAP_EN
   assign trap = !rst && (state_q == S_TRAP);
`else
   assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_multicycle_ctrl
//   Directed self-checking bench for cpu_multicycle_ctrl (MEM_WAIT_MAX=15).
//   Each cycle drives inputs just after posedge and compares the full output
//   vector on the following negedge against a hand-written expectation.
//   Expected vector layout:
//   {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src, alu_op[1:0],
//    mem_to_reg, reg_write, mem_err, trap, 1'b0, state[2:0]}
// -----------------------------------------------------------------------------
module tb_cpu_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] instruction;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_we, ir_write, pc_write, pc_src, alu_src;
   logic [1:0] alu_op;
   logic       mem_to_reg, reg_write, mem_err, trap;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] R  = 7'b0110011;
   localparam logic [6:0] I  = 7'b0010011;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;
   localparam logic [6:0] BR = 7'b1100011;
   localparam logic [6:0] JL = 7'b1101111;
   localparam logic [6:0] IL = 7'b1111111;

   cpu_multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .pc_src      (pc_src),
      .alu_src     (alu_src),
      .alu_op      (alu_op),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .mem_err     (mem_err),
      .trap        (trap),
      .state       (state)
   );

   always #5 clk = ~clk;

   logic [15:0] obs;
   assign obs = {mem_req, mem_we, ir_write, pc_write, pc_src, alu_src, alu_op,
                 mem_to_reg, reg_write, mem_err, trap, 1'b0, state};

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ev(
      input logic req, we, irw, pcw, pcs, asrc,
      input logic [1:0] aop,
      input logic m2r, rw, err, trp,
      input logic [2:0] st);
      return {req, we, irw, pcw, pcs, asrc, aop, m2r, rw, err, trp, 1'b0, st};
   endfunction

   // One clock cycle: drive, check at negedge, advance past next posedge.
   task automatic cyc(input string tag, input logic r, input logic rdy, input logic z,
                      input logic [6:0] ins, input logic [15:0] exp);
      rst         = r;
      mem_ready   = rdy;
      zero        = z;
      instruction = ins;
      @(negedge clk);
      check(tag, obs, exp);
      @(posedge clk);
      #1;
   endtask

   // Frequently used expectations (mem_err clear).
   logic [15:0] zv, f_done, f_wait, dec, wb;
   initial begin
      zv     = 16'h0000;
      f_done = ev(1,0,1,1,0,0,2'b00,0,0,0,0,3'd0);
      f_wait = ev(1,0,0,0,0,0,2'b00,0,0,0,0,3'd0);
      dec    = ev(0,0,0,0,0,0,2'b00,0,0,0,0,3'd1);
      wb     = ev(0,0,0,0,0,0,2'b00,0,1,0,0,3'd4);
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; instruction = 7'h00;
      @(posedge clk); #1;

      // Reset: all outputs zero even with mem_ready high.
      cyc("rst0", 1, 1, 0, R, zv);
      cyc("rst1", 1, 1, 0, R, zv);

      // R-type, zero-wait: 0,1,2,4 then FETCH.
      cyc("r_fetch", 0, 1, 0, R,    f_done);
      cyc("r_dec",   0, 1, 0, 7'h0, dec);
      cyc("r_exec",  0, 1, 0, 7'h0, ev(0,0,0,0,0,0,2'b10,0,0,0,0,3'd2));
      cyc("r_wb",    0, 1, 0, 7'h0, wb);

      // LOAD with 3 wait cycles in MEM: 8 cycles total.
      cyc("ld_fetch", 0, 1, 0, LD,   f_done);
      cyc("ld_dec",   0, 1, 0, 7'h0, dec);
      cyc("ld_exec",  0, 1, 0, 7'h0, ev(0,0,0,0,0,1,2'b00,0,0,0,0,3'd2));
      for (int i = 0; i < 3; i++)
         cyc($sformatf("ld_memwait%0d", i), 0, 0, 0, 7'h0, ev(1,0,0,0,0,0,2'b00,0,0,0,0,3'd3));
      cyc("ld_memdone", 0, 1, 0, 7'h0, ev(1,0,0,0,0,0,2'b00,0,0,0,0,3'd3));
      cyc("ld_wb",      0, 1, 0, 7'h0, ev(0,0,0,0,0,0,2'b00,1,1,0,0,3'd4));

      // BRANCH taken, then not taken; 3 cycles each.
      cyc("bt_fetch", 0, 1, 0, BR,   f_done);
      cyc("bt_dec",   0, 1, 0, 7'h0, dec);
      cyc("bt_exec",  0, 1, 1, 7'h0, ev(0,0,0,1,1,0,2'b01,0,0,0,0,3'd2));
      cyc("bn_fetch", 0, 1, 0, BR,   f_done);
      cyc("bn_dec",   0, 1, 0, 7'h0, dec);
      cyc("bn_exec",  0, 1, 0, 7'h0, ev(0,0,0,0,0,0,2'b01,0,0,0,0,3'd2));

      // I-type with one fetch wait cycle; opcode sampled only on completion.
      cyc("i_fwait",  0, 0, 0, JL,   f_wait);
      cyc("i_fetch",  0, 1, 0, I,    f_done);
      cyc("i_dec",    0, 1, 0, JL,   dec);
      cyc("i_exec",   0, 1, 0, JL,   ev(0,0,0,0,0,1,2'b10,0,0,0,0,3'd2));
      cyc("i_wb",     0, 1, 0, 7'h0, wb);

      // JAL.
      cyc("j_fetch",  0, 1, 0, JL,   f_done);
      cyc("j_dec",    0, 1, 0, 7'h0, dec);
      cyc("j_exec",   0, 1, 0, 7'h0, ev(0,0,0,1,1,0,2'b00,0,0,0,0,3'd2));
      cyc("j_wb",     0, 1, 0, 7'h0, wb);

      // Illegal opcode.
      cyc("il_fetch", 0, 1, 0, IL,   f_done);
      cyc("il_dec",   0, 1, 0, 7'h0, dec);
`ifdef CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++)
         cyc($sformatf("il_trap%0d", i), 0, 1, 0, 7'h0, ev(0,0,0,0,0,0,2'b00,0,0,0,1,3'd5));
`else
      cyc("il_nop",   0, 0, 0, 7'h0, f_wait);
`endif
      cyc("il_rst",   1, 1, 0, 7'h0, zv);

      // LOAD: 14 waits then ready on the cycle the count would hit the limit.
      cyc("lb_fetch", 0, 1, 0, LD,   f_done);
      cyc("lb_dec",   0, 1, 0, 7'h0, dec);
      cyc("lb_exec",  0, 1, 0, 7'h0, ev(0,0,0,0,0,1,2'b00,0,0,0,0,3'd2));
      for (int i = 1; i <= 14; i++)
         cyc($sformatf("lb_wait%0d", i), 0, 0, 0, 7'h0, ev(1,0,0,0,0,0,2'b00,0,0,0,0,3'd3));
      cyc("lb_done",  0, 1, 0, 7'h0, ev(1,0,0,0,0,0,2'b00,0,0,0,0,3'd3));
      cyc("lb_wb",    0, 1, 0, 7'h0, ev(0,0,0,0,0,0,2'b00,1,1,0,0,3'd4));
      cyc("lb_next",  0, 0, 0, 7'h0, f_wait);

      // STORE with 20 withheld cycles: mem_err visible from the 16th onward.
      cyc("st_fetch", 0, 1, 0, ST,   f_done);
      cyc("st_dec",   0, 1, 0, 7'h0, dec);
      cyc("st_exec",  0, 1, 0, 7'h0, ev(0,0,0,0,0,1,2'b00,0,0,0,0,3'd2));
      for (int i = 1; i <= 20; i++)
         cyc($sformatf("st_wait%0d", i), 0, 0, 0, 7'h0,
             ev(1,1,0,0,0,0,2'b00,0,0,(i > 15),0,3'd3));
      cyc("st_done",  0, 1, 0, 7'h0, ev(1,1,0,0,0,0,2'b00,0,0,1,0,3'd3));
      cyc("st_back",  0, 0, 0, 7'h0, ev(1,0,0,0,0,0,2'b00,0,0,1,0,3'd0));

      // Reset in MEM mid-wait: outputs drop, then fresh FETCH request.
      cyc("rm_fetch", 0, 1, 0, ST,   ev(1,0,1,1,0,0,2'b00,0,0,1,0,3'd0));
      cyc("rm_dec",   0, 1, 0, 7'h0, ev(0,0,0,0,0,0,2'b00,0,0,1,0,3'd1));
      cyc("rm_exec",  0, 1, 0, 7'h0, ev(0,0,0,0,0,1,2'b00,0,0,1,0,3'd2));
      cyc("rm_wait",  0, 0, 0, 7'h0, ev(1,1,0,0,0,0,2'b00,0,0,1,0,3'd3));
      cyc("rm_rst",   1, 0, 0, 7'h0, zv);
      cyc("rm_after", 0, 0, 0, 7'h0, f_wait);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
